csa_accum_seq: RTL and testbench

Sequential multi-operand accumulator controller built around a 3:2 carry-save compressor. It accepts a stream of Bits-wide unsigned operands over a valid/ready handshake and keeps the running total in redundant sum/carry form, so no carry propagates on the input path. On the beat marked last it runs one carry-propagate resolve cycle and presents the binary total on a valid/ready output. It sits in front of the shared adder datapath and sequences CSA reduction plus the final ripple add for dot-product and popcount-style reductions.

---
 rtl/csa_accum_seq_if.sv | 27 ++
 rtl/csa_accum_seq.sv | 79 +++++++
 tb/tb_csa_accum_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/csa_accum_seq_if.sv
// Operand-in / result-out handshake bundle for csa_accum_seq.
// The slave side is the accumulator. The master side is the producer and consumer.
interface csa_accum_seq_if #(
   parameter int BITS  = 64,
   parameter int GUARD = 8
);
   localparam int W = BITS + GUARD;

   logic            in_valid;
   logic            in_ready;
   logic [BITS-1:0] in_data;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_sum;
   logic [15:0]     out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count
   );
endinterface

// File: rtl/csa_accum_seq.sv
// Multi-operand accumulator. The running total is kept in carry-save form,
// and one ripple-add resolve cycle runs after the beat marked last.
module csa_accum_seq #(
   parameter int BITS  = 64,
   parameter int GUARD = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   csa_accum_seq_if.slave  io
);
   localparam int W = BITS + GUARD;

   typedef enum logic [1:0] {ACC, RESOLVE, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   s_q, c_q, res_q;
   logic [W-1:0]   x, maj;
   logic [15:0]    cnt_q;
   logic           acc_fire, out_fire;

   assign x        = {{GUARD{1'b0}}, io.in_data};
   assign maj      = (s_q & c_q) | (s_q & x) | (c_q & x);
   assign acc_fire = io.in_valid & (state_q == ACC);
   assign out_fire = io.out_ready & (state_q == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ACC;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ACC:     if (acc_fire && io.in_last) state_d = RESOLVE;
         RESOLVE: state_d = DONE;
         DONE:    if (out_fire) state_d = ACC;
         default: state_d = ACC;
      endcase
      if (flush) state_d = ACC;
   end

   // Outputs are decoded only from state and registers. No input reaches them combinationally.
   always_comb begin
      io.in_ready  = (state_q == ACC);
      io.out_valid = (state_q == DONE);
      io.out_sum   = res_q;
      io.out_count = cnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
         res_q <= '0;
      end else if (flush) begin
         // res_q is kept. It is not visible because out_valid is low in ACC.
         s_q   <= '0;
         c_q   <= '0;
         cnt_q <= '0;
      end else begin
         case (state_q)
            ACC: if (acc_fire) begin
               s_q   <= s_q ^ c_q ^ x;
               c_q   <= {maj[W-2:0], 1'b0};
               cnt_q <= (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            end
            RESOLVE: res_q <= s_q + c_q;
            DONE: if (out_fire) begin
               s_q   <= '0;
               c_q   <= '0;
               cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed table-driven bench for csa_accum_seq with hand-computed totals,
// multi-cycle corner sequences and a scoreboard-checked random stream.
module tb_csa_accum_seq;
   localparam int BITS = 64;
   localparam int GUARD = 8;
   localparam int W = BITS + GUARD;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   csa_accum_seq_if #(.BITS(BITS), .GUARD(GUARD)) bus ();

   csa_accum_seq #(.BITS(BITS), .GUARD(GUARD)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .io(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          n;
      logic [63:0] op [3];
      logic [71:0] exp_sum;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic beat(input logic [63:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_out(input string name);
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (bus.out_valid !== 1'b1) chk({name, "_timeout"}, 72'(bus.out_valid), 72'd1);
   endtask

   task automatic get_result(input string name, input logic [71:0] es, input logic [15:0] ec);
      wait_out(name);
      chk({name, "_sum"}, bus.out_sum, es);
      chk({name, "_cnt"}, 72'(bus.out_count), 72'(ec));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [71:0] sb;
      int nb, k;
      logic [63:0] d;

      vecs[0] = '{n: 3, op: '{64'd1, 64'd2, 64'd3}, exp_sum: 72'd6, exp_cnt: 16'd3};
      vecs[1] = '{n: 2, op: '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0},
                  exp_sum: 72'h1_0000_0000_0000_0000, exp_cnt: 16'd2};
      vecs[2] = '{n: 3, op: '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                  exp_sum: 72'h2_FFFF_FFFF_FFFF_FFFD, exp_cnt: 16'd3};
      vecs[3] = '{n: 1, op: '{64'h1234_5678, 64'd0, 64'd0}, exp_sum: 72'h1234_5678, exp_cnt: 16'd1};
      vecs[4] = '{n: 3, op: '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000},
                  exp_sum: 72'h1_8000_0000_0000_0000, exp_cnt: 16'd3};
      vecs[5] = '{n: 3, op: '{64'd0, 64'd0, 64'd0}, exp_sum: 72'd0, exp_cnt: 16'd3};

      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      #3;
      chk("rst_in_ready", 72'(bus.in_ready), 72'd1);
      chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
      chk("rst_out_sum", bus.out_sum, 72'd0);
      chk("rst_out_count", 72'(bus.out_count), 72'd0);
      #14 reset_n = 1'b1;
      tick();

      // 1,2,3,4 with out_ready held high: valid lasts exactly one cycle
      bus.out_ready = 1'b1;
      beat(64'd1, 1'b0); beat(64'd2, 1'b0); beat(64'd3, 1'b0); beat(64'd4, 1'b1);
      chk("g4_resolve_valid", 72'(bus.out_valid), 72'd0);
      chk("g4_resolve_ready", 72'(bus.in_ready), 72'd0);
      tick();
      chk("g4_valid", 72'(bus.out_valid), 72'd1);
      chk("g4_sum", bus.out_sum, 72'd10);
      chk("g4_cnt", 72'(bus.out_count), 72'd4);
      tick();
      chk("g4_valid_drop", 72'(bus.out_valid), 72'd0);
      chk("g4_in_ready", 72'(bus.in_ready), 72'd1);
      bus.out_ready = 1'b0;

      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < vecs[i].n; j++) beat(vecs[i].op[j], j == vecs[i].n - 1);
         get_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cnt);
      end

      // 256 full-scale operands: the guard bits must hold the whole total
      for (int i = 0; i < 256; i++) beat(64'hFFFF_FFFF_FFFF_FFFF, i == 255);
      get_result("full256", 72'hFF_FFFF_FFFF_FFFF_FF00, 16'd256);

      // Single beat followed by consumer stall
      beat(64'hDEAD, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 72'(bus.out_valid), 72'd1);
         chk("stall_sum", bus.out_sum, 72'hDEAD);
         chk("stall_in_ready", 72'(bus.in_ready), 72'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("stall_after_ready", 72'(bus.in_ready), 72'd1);
      chk("stall_after_valid", 72'(bus.out_valid), 72'd0);

      // Flush mid-group: the beat in the flush cycle is dropped
      beat(64'd10, 1'b0); beat(64'd20, 1'b0); beat(64'd30, 1'b0);
      flush = 1'b1;
      beat(64'd100, 1'b1);
      flush = 1'b0;
      chk("flush_acc_valid", 72'(bus.out_valid), 72'd0);
      beat(64'd5, 1'b0); beat(64'd6, 1'b1);
      get_result("flush_mid", 72'd11, 16'd2);

      // Flush in DONE: the stale result disappears and is never handshaken
      beat(64'd9, 1'b1);
      tick();
      chk("flushdone_pre", 72'(bus.out_valid), 72'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flushdone_valid", 72'(bus.out_valid), 72'd0);
      chk("flushdone_ready", 72'(bus.in_ready), 72'd1);
      beat(64'd3, 1'b0); beat(64'd4, 1'b1);
      get_result("flushdone_next", 72'd7, 16'd2);

      // Async reset between edges while in RESOLVE
      beat(64'd50, 1'b0); beat(64'd60, 1'b1);
      chk("arst_pre_ready", 72'(bus.in_ready), 72'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_in_ready", 72'(bus.in_ready), 72'd1);
      chk("arst_out_valid", 72'(bus.out_valid), 72'd0);
      chk("arst_out_sum", bus.out_sum, 72'd0);
      chk("arst_out_count", 72'(bus.out_count), 72'd0);
      reset_n = 1'b1;
      tick();
      beat(64'd7, 1'b0); beat(64'd8, 1'b1);
      get_result("arst_next", 72'd15, 16'd2);

      // Random groups with input gaps, stray in_last and output backpressure
      for (int g = 0; g < 1000; g++) begin
         nb = $urandom_range(1, 40);
         sb = '0;
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 4) == 0) begin
               bus.in_last = $urandom_range(0, 1) == 1;
               tick();
               bus.in_last = 1'b0;
            end
            d = {$urandom, $urandom};
            sb = sb + {8'd0, d};
            beat(d, b == nb - 1);
         end
         wait_out("rnd");
         k = $urandom_range(0, 3);
         for (int s = 0; s < k; s++) begin
            if (bus.out_valid !== 1'b1 || bus.out_sum !== sb) begin
               chk("rnd_hold_valid", 72'(bus.out_valid), 72'd1);
               chk("rnd_hold_sum", bus.out_sum, sb);
            end
            tick();
         end
         chk("rnd_sum", bus.out_sum, sb);
         chk("rnd_cnt", 72'(bus.out_count), 72'(nb));
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
